// File: rtl/axis_move_sequencer.sv
// Multi-axis stepper move sequencer.
// Accepts move commands into a small FIFO, then plays each move as a train of
// step pulses, one pulse per axis per step period, with per-axis limit-switch
// blocking, abort and sticky limit flags.
module axis_move_sequencer #(
  parameter int N_AXES  = 4,
  parameter int COUNT_W = 20,
  parameter int PER_W   = 20,
  parameter int DEPTH   = 4
) (
  input  logic                      i_Clock50MHz,
  input  logic                      i_Reset,
  input  logic                      i_CmdValid,
  output logic                      o_CmdReady,
  input  logic [N_AXES*COUNT_W-1:0] i_CmdSteps,
  input  logic [N_AXES-1:0]         i_CmdDir,
  input  logic [PER_W-1:0]          i_CmdPeriod,
  input  logic [N_AXES-1:0]         i_LimitStart,
  input  logic [N_AXES-1:0]         i_LimitEnd,
  input  logic                      i_Abort,
  output logic [N_AXES-1:0]         o_Step,
  output logic [N_AXES-1:0]         o_Dir,
  output logic                      o_Busy,
  output logic                      o_Waiting,
  output logic [N_AXES-1:0]         o_LimitHit,
  output logic [$clog2(DEPTH):0]    o_QueueCount
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int SW      = N_AXES * COUNT_W;
  localparam int ENTRY_W = SW + N_AXES + PER_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t state_q, state_nx;

  logic [ENTRY_W-1:0] fifo_mem [DEPTH];
  logic [ENTRY_W-1:0] head_q;
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic               push, pop;

  logic [COUNT_W-1:0] remaining_q [N_AXES];
  logic [N_AXES-1:0]  dir_q, pulse_q, limit_hit_q;
  logic [PER_W-1:0]   period_q, phase_q;
  logic [N_AXES-1:0]  blocked, start_mask, pulse_now;
  logic               all_zero, last_phase, high_half;
  logic [PER_W-1:0]   head_per;

  assign o_CmdReady   = (count_q != CW'(DEPTH)) && !i_Abort;
  assign push         = i_CmdValid && o_CmdReady;
  assign pop          = (state_q == S_IDLE) && (count_q != '0) && !i_Abort;
  assign o_QueueCount = count_q;
  assign o_Dir        = dir_q;
  assign o_LimitHit   = limit_hit_q;
  assign head_per     = head_q[SW+N_AXES +: PER_W];

  // FIFO storage; the head entry is captured on pop and consumed during LOAD
  always_ff @(posedge i_Clock50MHz) begin
    if (push) fifo_mem[wr_ptr_q] <= {i_CmdPeriod, i_CmdDir, i_CmdSteps};
    if (pop)  head_q <= fifo_mem[rd_ptr_q];
  end

  // FIFO pointers and occupancy; abort flushes ahead of any push or pop
  always_ff @(posedge i_Clock50MHz) begin
    if (i_Reset || i_Abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  // Per-axis blocking, start-of-period pulse decision and completion detect
  always_comb begin
    all_zero = 1'b1;
    for (int unsigned k = 0; k < N_AXES; k++) begin
      blocked[k]    = dir_q[k] ? i_LimitEnd[k] : i_LimitStart[k];
      start_mask[k] = (remaining_q[k] != '0) && !blocked[k];
      if (remaining_q[k] != '0) all_zero = 1'b0;
    end
    last_phase = (phase_q == period_q - 1'b1);
    high_half  = (phase_q < (period_q >> 1));
    // The phase-0 decision is not registered yet, so use it directly there
    pulse_now  = (phase_q == '0) ? start_mask : pulse_q;
    o_Step     = (state_q == S_RUN && high_half) ? pulse_now : '0;
  end

  // State register
  always_ff @(posedge i_Clock50MHz) begin
    if (i_Reset) state_q <= S_IDLE;
    else         state_q <= state_nx;
  end

  // Next-state and status outputs
  always_comb begin
    state_nx  = state_q;
    o_Busy    = 1'b0;
    o_Waiting = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_Waiting = (count_q == '0);
        if (pop) state_nx = S_LOAD;
      end
      S_LOAD: begin
        o_Busy   = 1'b1;
        state_nx = S_RUN;
      end
      S_RUN: begin
        o_Busy = 1'b1;
        if (last_phase && all_zero) state_nx = S_DONE;
      end
      S_DONE: begin
        o_Busy   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (i_Abort) state_nx = S_IDLE;
  end

  // Move datapath: latch the command, run the phase counter, count steps down
  always_ff @(posedge i_Clock50MHz) begin
    if (i_Reset) begin
      for (int unsigned k = 0; k < N_AXES; k++) remaining_q[k] <= '0;
      dir_q       <= '0;
      pulse_q     <= '0;
      limit_hit_q <= '0;
      period_q    <= PER_W'(2);
      phase_q     <= '0;
    end else if (i_Abort) begin
      for (int unsigned k = 0; k < N_AXES; k++) remaining_q[k] <= '0;
      pulse_q <= '0;
      phase_q <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          for (int unsigned k = 0; k < N_AXES; k++)
            remaining_q[k] <= head_q[k*COUNT_W +: COUNT_W];
          dir_q    <= head_q[SW +: N_AXES];
          period_q <= (head_per < PER_W'(2)) ? PER_W'(2) : head_per;
          phase_q  <= '0;
          pulse_q  <= '0;
        end
        S_RUN: begin
          phase_q <= last_phase ? '0 : phase_q + 1'b1;
          if (phase_q == '0) pulse_q <= start_mask;
          // An axis stopped by its limit drops its outstanding steps only
          for (int unsigned k = 0; k < N_AXES; k++) begin
            if (blocked[k] && remaining_q[k] != '0) begin
              remaining_q[k] <= '0;
              limit_hit_q[k] <= 1'b1;
            end else if (phase_q == '0 && start_mask[k]) begin
              remaining_q[k] <= remaining_q[k] - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_move_sequencer.sv
// Directed self-checking bench for axis_move_sequencer.
module tb_axis_move_sequencer;

  localparam int NA = 4;
  localparam int CW = 20;
  localparam int PW = 20;
  localparam int DP = 4;

  logic              clk = 1'b0;
  logic              i_Reset = 1'b1;
  logic              i_CmdValid = 1'b0;
  logic              o_CmdReady;
  logic [NA*CW-1:0]  i_CmdSteps = '0;
  logic [NA-1:0]     i_CmdDir = '0;
  logic [PW-1:0]     i_CmdPeriod = '0;
  logic [NA-1:0]     i_LimitStart = '0;
  logic [NA-1:0]     i_LimitEnd = '0;
  logic              i_Abort = 1'b0;
  logic [NA-1:0]     o_Step, o_Dir, o_LimitHit;
  logic              o_Busy, o_Waiting;
  logic [$clog2(DP):0] o_QueueCount;

  always #10 clk = ~clk;

  axis_move_sequencer #(
    .N_AXES(NA), .COUNT_W(CW), .PER_W(PW), .DEPTH(DP)
  ) dut (
    .i_Clock50MHz(clk), .i_Reset(i_Reset), .i_CmdValid(i_CmdValid),
    .o_CmdReady(o_CmdReady), .i_CmdSteps(i_CmdSteps), .i_CmdDir(i_CmdDir),
    .i_CmdPeriod(i_CmdPeriod), .i_LimitStart(i_LimitStart),
    .i_LimitEnd(i_LimitEnd), .i_Abort(i_Abort), .o_Step(o_Step),
    .o_Dir(o_Dir), .o_Busy(o_Busy), .o_Waiting(o_Waiting),
    .o_LimitHit(o_LimitHit), .o_QueueCount(o_QueueCount)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Pulse counters and per-move log (direction at first RUN cycle, idle gap before)
  int            rises [NA] = '{default: 0};
  logic [NA-1:0] prev_step = '0;
  int            busy_run = 0, idle_run = 0, gap_cur = 0, n_moves = 0;
  logic [NA-1:0] dir_log [32];
  int            gap_log [32];

  // Observe outputs on the falling edge, away from DUT updates
  always @(negedge clk) begin
    for (int k = 0; k < NA; k++)
      if (o_Step[k] && !prev_step[k]) rises[k]++;
    prev_step = o_Step;
    if (o_Busy) begin
      busy_run++;
      if (busy_run == 1) gap_cur = idle_run;
      if (busy_run == 2 && n_moves < 32) begin
        dir_log[n_moves] = o_Dir;
        gap_log[n_moves] = gap_cur;
        n_moves++;
      end
    end else begin
      if (busy_run != 0) idle_run = 0;
      busy_run = 0;
      idle_run++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NA*CW-1:0] steps4(input int a0, input int a1, input int a2, input int a3);
    return {CW'(a3), CW'(a2), CW'(a1), CW'(a0)};
  endfunction

  // Offer one command; returns one tick after the accepting edge
  task automatic push(input logic [NA*CW-1:0] st, input logic [NA-1:0] dr,
                      input int per, input int budget, input string tag);
    bit ok = 1'b0;
    i_CmdSteps  = st;
    i_CmdDir    = dr;
    i_CmdPeriod = PW'(per);
    i_CmdValid  = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_CmdReady) begin
        ok = 1'b1;
        break;
      end
    end
    check_val(tag, 32'(ok), 32'd1);
    sync();
    i_CmdValid = 1'b0;
  endtask

  task automatic wait_waiting(input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_Waiting) begin
        ok = 1'b1;
        break;
      end
    end
    check_val(tag, 32'(ok), 32'd1);
    sync();
  endtask

  // Cycle-accurate model of one unblocked move, started right after its push
  task automatic check_move(input logic [NA*CW-1:0] st, input logic [NA-1:0] dr, input int per);
    int p, nper, total;
    int s [NA];
    logic [NA-1:0] exp;
    p = (per < 2) ? 2 : per;
    nper = 1;
    for (int k = 0; k < NA; k++) begin
      s[k] = int'(st[k*CW +: CW]);
      if (s[k] > nper) nper = s[k];
    end
    total = p * nper;
    @(negedge clk);
    check_val("pop_cycle_busy", 32'(o_Busy), 32'd0);
    for (int i = 0; i <= total + 1; i++) begin
      @(negedge clk);
      exp = '0;
      if (i >= 1 && i <= total)
        for (int k = 0; k < NA; k++)
          if ((i - 1) / p < s[k] && (i - 1) % p < p / 2) exp[k] = 1'b1;
      check_val("busy_step", 32'({o_Busy, o_Step}), 32'({1'b1, exp}));
      if (i == 1) check_val("run_dir", 32'(o_Dir), 32'(dr));
    end
    @(negedge clk);
    check_val("waiting_after_move", 32'(o_Waiting), 32'd1);
    check_val("busy_after_move", 32'(o_Busy), 32'd0);
    sync();
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_count"}, 32'(o_QueueCount), 32'd0);
    check_val({tag, "_ready"}, 32'(o_CmdReady), 32'd1);
    check_val({tag, "_waiting"}, 32'(o_Waiting), 32'd1);
    check_val({tag, "_busy"}, 32'(o_Busy), 32'd0);
    check_val({tag, "_step"}, 32'(o_Step), 32'd0);
    check_val({tag, "_dir"}, 32'(o_Dir), 32'd0);
    check_val({tag, "_limithit"}, 32'(o_LimitHit), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int base, r0, r1, r2, r3, cnt;
    bit raised, seen;
    logic prv;
    logic [NA-1:0] exp_dirs [6];
    exp_dirs = '{4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011};

    // Reset values
    sync(); sync();
    i_Reset = 1'b0;
    @(negedge clk);
    check_reset_state("rst");
    sync();

    // Single move: steps {3,1,0,2}, period 4
    push(steps4(3, 1, 0, 2), 4'b0101, 4, 4, "push_single");
    check_move(steps4(3, 1, 0, 2), 4'b0101, 4);

    // Queue full and back-to-back moves in FIFO order
    base = n_moves;
    push(steps4(5, 0, 0, 0), 4'b1111, 10, 4, "push_a");
    push(steps4(1, 0, 0, 0), 4'b0001, 2, 4, "push_b");
    @(negedge clk);
    check_val("count_push_pop", 32'(o_QueueCount), 32'd1);
    sync();
    push(steps4(1, 0, 0, 0), 4'b0010, 2, 4, "push_c");
    push(steps4(1, 0, 0, 0), 4'b0100, 2, 4, "push_d");
    push(steps4(1, 0, 0, 0), 4'b1000, 2, 4, "push_e");
    @(negedge clk);
    check_val("count_full", 32'(o_QueueCount), 32'd4);
    check_val("ready_full", 32'(o_CmdReady), 32'd0);
    sync();
    push(steps4(1, 0, 0, 0), 4'b0011, 2, 200, "push_f_after_pop");
    @(negedge clk);
    check_val("count_refill", 32'(o_QueueCount), 32'd4);
    wait_waiting(400, "queue_drain_timeout");
    for (int j = 0; j < 6; j++) check_val("fifo_order_dir", 32'(dir_log[base + j]), 32'(exp_dirs[j]));
    for (int j = 1; j < 6; j++) check_val("b2b_gap", 32'(gap_log[base + j]), 32'd1);

    // Limit hit on axis 1 after its 4th pulse
    r0 = rises[0]; r1 = rises[1]; r2 = rises[2]; r3 = rises[3];
    push(steps4(3, 10, 12, 0), 4'b0010, 4, 4, "push_limit");
    cnt = 0; prv = 1'b0; raised = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (o_Step[1] && !prv) cnt++;
      prv = o_Step[1];
      if (cnt == 4 && !o_Step[1]) begin
        i_LimitEnd[1] = 1'b1;
        raised = 1'b1;
        break;
      end
    end
    check_val("limit_raise_timeout", 32'(raised), 32'd1);
    wait_waiting(300, "limit_move_timeout");
    check_val("limit_ax0_pulses", 32'(rises[0] - r0), 32'd3);
    check_val("limit_ax1_pulses", 32'(rises[1] - r1), 32'd4);
    check_val("limit_ax2_pulses", 32'(rises[2] - r2), 32'd12);
    check_val("limit_ax3_pulses", 32'(rises[3] - r3), 32'd0);
    check_val("limit_hit", 32'(o_LimitHit), 32'b0010);
    i_LimitEnd = '0;

    // Abort mid-RUN with two entries queued; a same-cycle push is dropped
    push(steps4(20, 0, 0, 0), 4'b0000, 4, 4, "push_ab_a");
    push(steps4(2, 0, 0, 0), 4'b0000, 4, 4, "push_ab_b");
    push(steps4(2, 0, 0, 0), 4'b0000, 4, 4, "push_ab_c");
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_Step[0]) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("abort_pulse_seen", 32'(seen), 32'd1);
    check_val("abort_count_before", 32'(o_QueueCount), 32'd2);
    sync();
    i_Abort = 1'b1;
    i_CmdSteps = steps4(1, 1, 1, 1);
    i_CmdValid = 1'b1;
    @(negedge clk);
    check_val("abort_ready_low", 32'(o_CmdReady), 32'd0);
    sync();
    i_Abort = 1'b0;
    i_CmdValid = 1'b0;
    @(negedge clk);
    check_val("abort_step", 32'(o_Step), 32'd0);
    check_val("abort_count", 32'(o_QueueCount), 32'd0);
    check_val("abort_busy", 32'(o_Busy), 32'd0);
    check_val("abort_waiting", 32'(o_Waiting), 32'd1);
    repeat (4) @(negedge clk);
    check_val("abort_still_idle", 32'({o_Waiting, o_Busy}), 32'b10);
    check_val("abort_keeps_limithit", 32'(o_LimitHit), 32'b0010);
    sync();

    // Period clamp and zero move
    push(steps4(2, 0, 0, 0), 4'b0000, 1, 4, "push_per1");
    check_move(steps4(2, 0, 0, 0), 4'b0000, 1);
    push(steps4(1, 1, 0, 0), 4'b0011, 0, 4, "push_per0");
    check_move(steps4(1, 1, 0, 0), 4'b0011, 0);
    push(steps4(0, 0, 0, 0), 4'b1001, 3, 4, "push_zero");
    check_move(steps4(0, 0, 0, 0), 4'b1001, 3);

    // Reset mid-move drops the active move and the queue
    push(steps4(20, 0, 0, 0), 4'b0110, 4, 4, "push_rst_a");
    push(steps4(3, 0, 0, 0), 4'b0000, 4, 4, "push_rst_b");
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_Step[0]) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("rst_pulse_seen", 32'(seen), 32'd1);
    sync();
    i_Reset = 1'b1;
    sync();
    i_Reset = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    repeat (4) @(negedge clk);
    check_val("midrst_idle_after", 32'({o_Waiting, o_Busy}), 32'b10);
    check_val("midrst_count_after", 32'(o_QueueCount), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
